// File: rtl/mini_src_pkg.sv
// Shared definitions for the Mini SRC control sequencer: opcodes, IR field
// positions, sequencer state encoding and ALU op one-hot bit positions.
package mini_src_pkg;

  localparam int unsigned IR_W   = 32;
  localparam int unsigned OPC_W  = 5;
  localparam int unsigned REG_W  = 4;
  localparam int unsigned NREG   = 16;
  localparam int unsigned NOP    = 13;
  localparam int unsigned STEP_W = 4;

  localparam int unsigned OPC_MSB = 31;
  localparam int unsigned OPC_LSB = 27;
  localparam int unsigned RA_MSB  = 26;
  localparam int unsigned RA_LSB  = 23;
  localparam int unsigned RB_MSB  = 22;
  localparam int unsigned RB_LSB  = 19;
  localparam int unsigned RC_MSB  = 18;
  localparam int unsigned RC_LSB  = 15;

  localparam logic [OPC_W-1:0] OPC_ADD  = 5'b00011;
  localparam logic [OPC_W-1:0] OPC_SUB  = 5'b00100;
  localparam logic [OPC_W-1:0] OPC_AND  = 5'b00101;
  localparam logic [OPC_W-1:0] OPC_OR   = 5'b00110;
  localparam logic [OPC_W-1:0] OPC_ROR  = 5'b00111;
  localparam logic [OPC_W-1:0] OPC_ROL  = 5'b01000;
  localparam logic [OPC_W-1:0] OPC_SHR  = 5'b01001;
  localparam logic [OPC_W-1:0] OPC_SHRA = 5'b01010;
  localparam logic [OPC_W-1:0] OPC_SHL  = 5'b01011;
  localparam logic [OPC_W-1:0] OPC_DIV  = 5'b01111;
  localparam logic [OPC_W-1:0] OPC_MUL  = 5'b10000;
  localparam logic [OPC_W-1:0] OPC_NEG  = 5'b10001;
  localparam logic [OPC_W-1:0] OPC_NOT  = 5'b10010;

  // Bit positions inside the 13-bit ALU op one-hot
  localparam int unsigned OP_AND  = 12;
  localparam int unsigned OP_OR   = 11;
  localparam int unsigned OP_ADD  = 10;
  localparam int unsigned OP_SUB  = 9;
  localparam int unsigned OP_MUL  = 8;
  localparam int unsigned OP_DIV  = 7;
  localparam int unsigned OP_SHR  = 6;
  localparam int unsigned OP_SHRA = 5;
  localparam int unsigned OP_SHL  = 4;
  localparam int unsigned OP_ROR  = 3;
  localparam int unsigned OP_ROL  = 2;
  localparam int unsigned OP_NEG  = 1;
  localparam int unsigned OP_NOT  = 0;

  typedef enum logic [STEP_W-1:0] {
    S_IDLE = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T2   = 4'd3,
    S_T3   = 4'd4,
    S_T4   = 4'd5,
    S_T5   = 4'd6,
    S_T6   = 4'd7
  } state_e;

  typedef enum logic [1:0] {
    CLS_ALU     = 2'd0,
    CLS_MULDIV  = 2'd1,
    CLS_UNARY   = 2'd2,
    CLS_ILLEGAL = 2'd3
  } op_class_e;

  function automatic logic [NREG-1:0] reg_onehot(input logic [REG_W-1:0] idx);
    return NREG'(1) << idx;
  endfunction

endpackage

// File: rtl/ir_decode.sv
// Combinational instruction decoder: opcode class, ALU op one-hot and
// one-hot register selects for the Ra/Rb/Rc fields of the IR.
module ir_decode
  import mini_src_pkg::*;
(
  input  logic [IR_W-1:0] ir,
  output op_class_e       op_class,
  output logic [NOP-1:0]  op_onehot,
  output logic [NREG-1:0] ra_oh,
  output logic [NREG-1:0] rb_oh,
  output logic [NREG-1:0] rc_oh
);

  logic [OPC_W-1:0] opcode;
  logic             unused_ir_bits;

  assign opcode         = ir[OPC_MSB:OPC_LSB];
  assign ra_oh          = reg_onehot(ir[RA_MSB:RA_LSB]);
  assign rb_oh          = reg_onehot(ir[RB_MSB:RB_LSB]);
  assign rc_oh          = reg_onehot(ir[RC_MSB:RC_LSB]);
  assign unused_ir_bits = ^ir[RC_LSB-1:0];

  always_comb begin
    op_class  = CLS_ILLEGAL;
    op_onehot = '0;
    case (opcode)
      OPC_ADD:  begin op_class = CLS_ALU;    op_onehot[OP_ADD]  = 1'b1; end
      OPC_SUB:  begin op_class = CLS_ALU;    op_onehot[OP_SUB]  = 1'b1; end
      OPC_AND:  begin op_class = CLS_ALU;    op_onehot[OP_AND]  = 1'b1; end
      OPC_OR:   begin op_class = CLS_ALU;    op_onehot[OP_OR]   = 1'b1; end
      OPC_ROR:  begin op_class = CLS_ALU;    op_onehot[OP_ROR]  = 1'b1; end
      OPC_ROL:  begin op_class = CLS_ALU;    op_onehot[OP_ROL]  = 1'b1; end
      OPC_SHR:  begin op_class = CLS_ALU;    op_onehot[OP_SHR]  = 1'b1; end
      OPC_SHRA: begin op_class = CLS_ALU;    op_onehot[OP_SHRA] = 1'b1; end
      OPC_SHL:  begin op_class = CLS_ALU;    op_onehot[OP_SHL]  = 1'b1; end
      OPC_DIV:  begin op_class = CLS_MULDIV; op_onehot[OP_DIV]  = 1'b1; end
      OPC_MUL:  begin op_class = CLS_MULDIV; op_onehot[OP_MUL]  = 1'b1; end
      OPC_NEG:  begin op_class = CLS_UNARY;  op_onehot[OP_NEG]  = 1'b1; end
      OPC_NOT:  begin op_class = CLS_UNARY;  op_onehot[OP_NOT]  = 1'b1; end
      default:  begin op_class = CLS_ILLEGAL; op_onehot = '0; end
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired T-step sequencer for the Mini SRC datapath: fetch, then execute
// of ALU, MUL/DIV and NEG/NOT instructions. Strobes are Moore outputs of step + IR.
module control_unit
  import mini_src_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic [31:0] ir,
  output logic [15:0] Rout,
  output logic [15:0] Rin,
  output logic        HIout,
  output logic        LOout,
  output logic        Zhighout,
  output logic        Zlowout,
  output logic        PCout,
  output logic        MDRout,
  output logic        HIin,
  output logic        LOin,
  output logic        PCin,
  output logic        IRin,
  output logic        Zin,
  output logic        Yin,
  output logic        MARin,
  output logic        MDRin,
  output logic        Read,
  output logic        IncPC,
  output logic        AND,
  output logic        OR,
  output logic        ADD,
  output logic        SUB,
  output logic        MUL,
  output logic        DIV,
  output logic        SHR,
  output logic        SHRA,
  output logic        SHL,
  output logic        ROR,
  output logic        ROL,
  output logic        NEG,
  output logic        NOT,
  output logic        illegal,
  output logic [3:0]  step
);

  state_e          state_q, state_d, end_state;
  op_class_e       op_class;
  logic [NOP-1:0]  op_onehot;
  logic [NOP-1:0]  alu_op;
  logic [NREG-1:0] ra_oh, rb_oh, rc_oh;

  ir_decode u_ir_decode (
    .ir        (ir),
    .op_class  (op_class),
    .op_onehot (op_onehot),
    .ra_oh     (ra_oh),
    .rb_oh     (rb_oh),
    .rc_oh     (rc_oh)
  );

  // State register; reset takes priority over everything
  always_ff @(posedge clk) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next step; run is only consulted in IDLE and at the final step
  always_comb begin
    end_state = run ? S_T0 : S_IDLE;
    state_d   = state_q;
    case (state_q)
      S_IDLE:  state_d = run ? S_T0 : S_IDLE;
      S_T0:    state_d = S_T1;
      S_T1:    state_d = S_T2;
      S_T2:    state_d = S_T3;
      S_T3:    state_d = (op_class == CLS_ILLEGAL) ? end_state : S_T4;
      S_T4:    state_d = (op_class == CLS_UNARY)   ? end_state : S_T5;
      S_T5:    state_d = (op_class == CLS_ALU)     ? end_state : S_T6;
      S_T6:    state_d = end_state;
      default: state_d = S_IDLE;
    endcase
  end

  // Strobe decode; the IR is only looked at from T3 onward
  always_comb begin
    Rout = '0; Rin = '0; alu_op = '0;
    HIout = 1'b0; LOout = 1'b0; Zhighout = 1'b0; Zlowout = 1'b0;
    PCout = 1'b0; MDRout = 1'b0;
    HIin = 1'b0; LOin = 1'b0; PCin = 1'b0; IRin = 1'b0; Zin = 1'b0;
    Yin = 1'b0; MARin = 1'b0; MDRin = 1'b0;
    Read = 1'b0; IncPC = 1'b0; illegal = 1'b0;
    case (state_q)
      S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; PCin = 1'b1; end
      S_T1: begin Read = 1'b1; MDRin = 1'b1; end
      S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
      S_T3: begin
        case (op_class)
          CLS_ALU:    begin Rout = rb_oh; Yin = 1'b1; end
          CLS_MULDIV: begin Rout = ra_oh; Yin = 1'b1; end
          CLS_UNARY:  begin Rout = rb_oh; alu_op = op_onehot; Zin = 1'b1; end
          default:    illegal = 1'b1;
        endcase
      end
      S_T4: begin
        case (op_class)
          CLS_ALU:    begin Rout = rc_oh; alu_op = op_onehot; Zin = 1'b1; end
          CLS_MULDIV: begin Rout = rb_oh; alu_op = op_onehot; Zin = 1'b1; end
          CLS_UNARY:  begin Zlowout = 1'b1; Rin = ra_oh; end
          default:    ;
        endcase
      end
      S_T5: begin
        case (op_class)
          CLS_ALU:    begin Zlowout = 1'b1; Rin = ra_oh; end
          CLS_MULDIV: begin Zlowout = 1'b1; LOin = 1'b1; end
          default:    ;
        endcase
      end
      S_T6: begin
        if (op_class == CLS_MULDIV) begin
          Zhighout = 1'b1;
          HIin     = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign AND  = alu_op[OP_AND];
  assign OR   = alu_op[OP_OR];
  assign ADD  = alu_op[OP_ADD];
  assign SUB  = alu_op[OP_SUB];
  assign MUL  = alu_op[OP_MUL];
  assign DIV  = alu_op[OP_DIV];
  assign SHR  = alu_op[OP_SHR];
  assign SHRA = alu_op[OP_SHRA];
  assign SHL  = alu_op[OP_SHL];
  assign ROR  = alu_op[OP_ROR];
  assign ROL  = alu_op[OP_ROL];
  assign NEG  = alu_op[OP_NEG];
  assign NOT  = alu_op[OP_NOT];
  assign step = STEP_W'(state_q);

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: hand-computed strobe sets per T-step for
// div, add, neg, shl (R0/R15 selects), an illegal opcode, and reset/run handling.
module tb_control_unit;

  logic        clk, reset, run;
  logic [31:0] ir;
  logic [15:0] Rout, Rin;
  logic HIout, LOout, Zhighout, Zlowout, PCout, MDRout;
  logic HIin, LOin, PCin, IRin, Zin, Yin, MARin, MDRin, Read, IncPC;
  logic AND, OR, ADD, SUB, MUL, DIV, SHR, SHRA, SHL, ROR, ROL, NEG, NOT;
  logic illegal;
  logic [3:0] step;

  int n_vec = 0;
  int n_err = 0;

  // Control strobe masks: {HIout,LOout,Zhighout,Zlowout,PCout,MDRout,HIin,LOin,
  //                        PCin,IRin,Zin,Yin,MARin,MDRin,Read,IncPC,illegal}
  localparam logic [16:0] C_NONE  = 17'h0;
  localparam logic [16:0] C_HIOUT = 17'h10000;
  localparam logic [16:0] C_ZHI   = 17'h04000;
  localparam logic [16:0] C_ZLO   = 17'h02000;
  localparam logic [16:0] C_PCOUT = 17'h01000;
  localparam logic [16:0] C_MDROUT= 17'h00800;
  localparam logic [16:0] C_HIIN  = 17'h00400;
  localparam logic [16:0] C_LOIN  = 17'h00200;
  localparam logic [16:0] C_PCIN  = 17'h00100;
  localparam logic [16:0] C_IRIN  = 17'h00080;
  localparam logic [16:0] C_ZIN   = 17'h00040;
  localparam logic [16:0] C_YIN   = 17'h00020;
  localparam logic [16:0] C_MARIN = 17'h00010;
  localparam logic [16:0] C_MDRIN = 17'h00008;
  localparam logic [16:0] C_READ  = 17'h00004;
  localparam logic [16:0] C_INCPC = 17'h00002;
  localparam logic [16:0] C_ILL   = 17'h00001;

  // ALU op masks: {AND,OR,ADD,SUB,MUL,DIV,SHR,SHRA,SHL,ROR,ROL,NEG,NOT}
  localparam logic [12:0] A_NONE = 13'h0000;
  localparam logic [12:0] A_ADD  = 13'h0400;
  localparam logic [12:0] A_DIV  = 13'h0080;
  localparam logic [12:0] A_SHL  = 13'h0010;
  localparam logic [12:0] A_NEG  = 13'h0002;

  logic [16:0] ctl_obs;
  logic [12:0] alu_obs;
  assign ctl_obs = {HIout, LOout, Zhighout, Zlowout, PCout, MDRout, HIin, LOin,
                    PCin, IRin, Zin, Yin, MARin, MDRin, Read, IncPC, illegal};
  assign alu_obs = {AND, OR, ADD, SUB, MUL, DIV, SHR, SHRA, SHL, ROR, ROL, NEG, NOT};

  control_unit dut (
    .clk(clk), .reset(reset), .run(run), .ir(ir),
    .Rout(Rout), .Rin(Rin),
    .HIout(HIout), .LOout(LOout), .Zhighout(Zhighout), .Zlowout(Zlowout),
    .PCout(PCout), .MDRout(MDRout),
    .HIin(HIin), .LOin(LOin), .PCin(PCin), .IRin(IRin), .Zin(Zin), .Yin(Yin),
    .MARin(MARin), .MDRin(MDRin), .Read(Read), .IncPC(IncPC),
    .AND(AND), .OR(OR), .ADD(ADD), .SUB(SUB), .MUL(MUL), .DIV(DIV),
    .SHR(SHR), .SHRA(SHRA), .SHL(SHL), .ROR(ROR), .ROL(ROL),
    .NEG(NEG), .NOT(NOT), .illegal(illegal), .step(step)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_state(input string tag, input logic [3:0] st,
                              input logic [15:0] rout, input logic [15:0] rin,
                              input logic [16:0] ctl, input logic [12:0] alu);
    chk({tag, ".step"}, 32'(step),    32'(st));
    chk({tag, ".rout"}, 32'(Rout),    32'(rout));
    chk({tag, ".rin"},  32'(Rin),     32'(rin));
    chk({tag, ".ctl"},  32'(ctl_obs), 32'(ctl));
    chk({tag, ".alu"},  32'(alu_obs), 32'(alu));
  endtask

  task automatic expect_idle(input string tag);
    expect_state(tag, 4'd0, 16'h0, 16'h0, C_NONE, A_NONE);
  endtask

  // Checks T0..T2 starting in T0 and leaves the sequencer in T3
  task automatic fetch(input string tag);
    expect_state({tag, ".t0"}, 4'd1, 16'h0, 16'h0, C_PCOUT | C_MARIN | C_INCPC | C_PCIN, A_NONE);
    tick();
    expect_state({tag, ".t1"}, 4'd2, 16'h0, 16'h0, C_READ | C_MDRIN, A_NONE);
    tick();
    expect_state({tag, ".t2"}, 4'd3, 16'h0, 16'h0, C_MDROUT | C_IRIN, A_NONE);
    tick();
  endtask

  initial begin
    reset = 1'b0; run = 1'b0; ir = 32'h0;
    tick(); expect_idle("rst0");
    tick(); expect_idle("rst1");
    reset = 1'b1;
    tick(); expect_idle("idle0");
    tick(); expect_idle("idle1");

    // div R2,R6
    ir = 32'h79300000; run = 1'b1;
    tick(); fetch("div");
    expect_state("div.t3", 4'd4, 16'h0004, 16'h0, C_YIN, A_NONE); tick();
    expect_state("div.t4", 4'd5, 16'h0040, 16'h0, C_ZIN, A_DIV); tick();
    expect_state("div.t5", 4'd6, 16'h0, 16'h0, C_ZLO | C_LOIN, A_NONE); tick();
    expect_state("div.t6", 4'd7, 16'h0, 16'h0, C_ZHI | C_HIIN, A_NONE); tick();

    // add R5,R2,R4 follows with no bubble; run dropped at its last step
    ir = 32'h1A920000;
    fetch("add");
    expect_state("add.t3", 4'd4, 16'h0004, 16'h0, C_YIN, A_NONE); tick();
    expect_state("add.t4", 4'd5, 16'h0010, 16'h0, C_ZIN, A_ADD); tick();
    expect_state("add.t5", 4'd6, 16'h0, 16'h0020, C_ZLO, A_NONE);
    run = 1'b0;
    tick(); expect_idle("add.end");
    tick(); expect_idle("add.stay");

    // neg R1,R7 with run dropped right after start: must still complete
    ir = 32'h88B80000; run = 1'b1;
    tick(); run = 1'b0;
    fetch("neg");
    expect_state("neg.t3", 4'd4, 16'h0080, 16'h0, C_ZIN, A_NEG); tick();
    expect_state("neg.t4", 4'd5, 16'h0, 16'h0002, C_ZLO, A_NONE); tick();
    expect_idle("neg.end");

    // unsupported opcode, then shl R15,R0,R15 back to back
    ir = 32'hF8000000; run = 1'b1;
    tick(); fetch("ill");
    expect_state("ill.t3", 4'd4, 16'h0, 16'h0, C_ILL, A_NONE); tick();
    ir = 32'h5F878000;
    fetch("shl");
    expect_state("shl.t3", 4'd4, 16'h0001, 16'h0, C_YIN, A_NONE); tick();
    expect_state("shl.t4", 4'd5, 16'h8000, 16'h0, C_ZIN, A_SHL); tick();
    expect_state("shl.t5", 4'd6, 16'h0, 16'h8000, C_ZLO, A_NONE); tick();

    // div again, abandoned by reset at T4
    ir = 32'h79300000;
    fetch("div2");
    expect_state("div2.t3", 4'd4, 16'h0004, 16'h0, C_YIN, A_NONE); tick();
    expect_state("div2.t4", 4'd5, 16'h0040, 16'h0, C_ZIN, A_DIV);
    reset = 1'b0;
    tick(); expect_idle("div2.rst");
    reset = 1'b1; run = 1'b0;
    tick(); expect_idle("div2.after");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/control_unit.md
# control_unit

Hardwired control sequencer for the Mini SRC datapath. It drives every strobe the datapath accepts: register/bus selects, ALU op one-hots, Read and IncPC. It generates the same T-step sequences that directed benches previously hand-drove: fetch, then execute of register-register ALU, shift/rotate, MUL/DIV and NEG/NOT. It sits beside `datapath` and takes the instruction register value back from it.

## Interface
- No parameters.
- `clk`  in  1  system clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `run`  in  1  permits start of a new instruction fetch.
- `ir`  in  32  current IR contents from datapath.
- `Rout`  out  16  one-hot bus-drive select for R0..R15.
- `Rin`  out  16  one-hot load enable for R0..R15.
- `HIout`, `LOout`, `Zhighout`, `Zlowout`, `PCout`, `MDRout`  out  1 each  bus drivers.
- `HIin`, `LOin`, `PCin`, `IRin`, `Zin`, `Yin`, `MARin`, `MDRin`  out  1 each  load enables.
- `Read`, `IncPC`  out  1 each  memory-read and PC-increment strobes.
- `AND`, `OR`, `ADD`, `SUB`, `MUL`, `DIV`, `SHR`, `SHRA`, `SHL`, `ROR`, `ROL`, `NEG`, `NOT`  out  1 each  ALU op select, at most one high.
- `illegal`  out  1  one-cycle pulse on unsupported opcode.
- `step`  out  4  current state encoding, for debug.

## Operation
- IR fields:
  - opcode `ir[31:27]`
  - Ra `ir[26:23]`
  - Rb `ir[22:19]`
  - Rc `ir[18:15]`
- Supported opcodes:
  - add 00011, sub 00100, and 00101, or 00110
  - ror 00111, rol 01000, shr 01001, shra 01010, shl 01011
  - div 01111, mul 10000, neg 10001, not 10010
- States: IDLE, T0..T6.
- IDLE: all strobes 0. Moves to T0 when `run`=1.
- Fetch steps (all opcodes):
  - T0: PCout, MARin, IncPC, PCin.
  - T1: Read, MDRin.
  - T2: MDRout, IRin.
- ALU group (add..shl), Ra ← Rb op Rc:
  - T3: Rout[Rb], Yin.
  - T4: Rout[Rc], op, Zin.
  - T5: Zlowout, Rin[Ra].
- MUL/DIV, (HI,LO) ← Ra op Rb:
  - T3: Rout[Ra], Yin.
  - T4: Rout[Rb], op, Zin.
  - T5: Zlowout, LOin.
  - T6: Zhighout, HIin.
- NEG/NOT, Ra ← op Rb:
  - T3: Rout[Rb], op, Zin.
  - T4: Zlowout, Rin[Ra].
- Unsupported opcode: at T3, `illegal`=1 and no other strobe. The instruction ends there.
- End of instruction: next state is T0 if `run`=1, else IDLE.
- Invariants:
  - At most one bus driver high in any cycle.
  - At most one Rin bit and at most one ALU op high.
  - R0 is treated like any other register.

## Timing
- State register updates on posedge `clk`. All outputs are Moore, decoded from state plus registered `ir`. They are valid for the whole cycle, and the datapath captures at the next edge.
- `ir` is sampled by the decoder from T3 onward. The decoder must not use `ir` during T0..T2.
- Reset:
  - `reset`=0 at an edge forces IDLE, overriding every other condition.
  - All outputs are 0 in the next cycle; `step`=0.
  - Reset mid-instruction abandons it with no trailing strobes.
- `run` is sampled only in IDLE and at the last step of an instruction. Deasserting it mid-instruction does not stop the instruction.
- Latency per instruction:
  - ALU: 6 cycles.
  - MUL/DIV: 7 cycles.
  - NEG/NOT: 5 cycles.
  - Illegal: 4 cycles.
- Back-to-back instructions with `run` held high have no bubble cycles.

## Structure
- `mini_src_pkg` holds:
  - opcode localparams
  - state encoding (IDLE=0, T0..T6=1..7)
  - IR field bit positions
- One sub-module, `ir_decode`, is purely combinational. It takes `ir` and outputs:
  - opcode class (ALU / MULDIV / UNARY / ILLEGAL)
  - 13-bit op one-hot
  - Ra, Rb, Rc one-hot (16 bits each)
- `control_unit` holds the state register and output decode.

## Test plan
- Reset held 0 for 2 cycles, `run`=0 → every output 0 and `step`=0. After release with `run`=0, it stays IDLE.
- `ir`=0x79300000 (div R2,R6), `run`=1 → steps in order:
  - T3: Rout=0x0004, Yin.
  - T4: Rout=0x0040, DIV, Zin.
  - T5: Zlowout, LOin.
  - T6: Zhighout, HIin.
  - Then T0.
- `ir`=0x1A920000 (add R5,R2,R4) → steps in order:
  - T3: Rout=0x0004, Yin.
  - T4: Rout=0x0010, ADD, Zin.
  - T5: Zlowout, Rin=0x0020.
- `ir`=0x88B80000 (neg R1,R7) → steps in order:
  - T3: Rout=0x0080, NEG, Zin.
  - T4: Zlowout, Rin=0x0002.
  - Total 5 cycles.
- `ir`=0xF8000000 → `illegal` high exactly one cycle at T3, no other strobes, next state T0.
- `reset`=0 during T4 of div → next cycle IDLE with DIV/Zin/HIin/LOin all 0. Also check `run`=0 at the end of add → IDLE.
